// File: rtl/tx_control.sv
// SPI-side TX command handler: decodes commands, assembles 10-bit words and loads the TX FIFO.
// Optional macro TX_STALL_EN: hold in TX_LOAD while tx_full instead of dropping the word.
module tx_control #(
    parameter logic [3:0] CMD_TX       = 4'h4,
    parameter logic [3:0] CMD_TX_RESET = 4'h6,
    parameter int         COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   spi_cs,
    input  logic [7:0]             spi_rx_data,
    input  logic                   spi_rx_strobe,
    output logic [7:0]             spi_tx_data,
    output logic                   spi_tx_strobe,
    output logic                   tx_reset,
    input  logic                   tx_active,
    input  logic                   tx_full,
    output logic [9:0]             tx_data,
    output logic                   tx_load_strobe,
    output logic [COUNT_WIDTH-1:0] word_count
);

    // state       | meaning
    // ST_IDLE     | waiting for a command byte
    // ST_RESET    | pulse tx_reset for one cycle
    // ST_STATUS   | send status byte to host
    // ST_HIGH     | waiting for word bits 9:8
    // ST_LOW      | waiting for word bits 7:0
    // ST_LOAD     | write assembled word into TX FIFO
    typedef enum logic [2:0] {
        ST_IDLE, ST_RESET, ST_STATUS, ST_HIGH, ST_LOW, ST_LOAD
    } state_t;

    state_t     state, state_next;
    logic       overflow;
    logic [9:0] word_buffer;
    logic       start_go, reset_go, status_go, high_go, low_go, load_go, drop_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            spi_tx_data    <= 8'h00;
            spi_tx_strobe  <= 1'b0;
            tx_reset       <= 1'b0;
            tx_data        <= 10'h000;
            tx_load_strobe <= 1'b0;
            word_count     <= '0;
            overflow       <= 1'b0;
            word_buffer    <= 10'h000;
        end else begin
            state          <= state_next;
            spi_tx_strobe  <= status_go;
            tx_reset       <= reset_go;
            tx_load_strobe <= load_go;
            if (status_go)
                spi_tx_data <= {tx_full, overflow, tx_active, 5'b00000};
            if (high_go)
                word_buffer[9:8] <= spi_rx_data[1:0];
            if (low_go)
                word_buffer[7:0] <= spi_rx_data;
            if (load_go) begin
                tx_data <= word_buffer;
                if (word_count != {COUNT_WIDTH{1'b1}})
                    word_count <= word_count + 1'b1;
            end
            if (drop_go)
                overflow <= 1'b1;
            if (start_go) begin
                word_count <= '0;
                overflow   <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        start_go   = 1'b0;
        reset_go   = 1'b0;
        status_go  = 1'b0;
        high_go    = 1'b0;
        low_go     = 1'b0;
        load_go    = 1'b0;
        drop_go    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (spi_rx_strobe) begin
                    if (spi_rx_data[3:0] == CMD_TX) begin
                        start_go   = 1'b1;
                        state_next = ST_STATUS;
                    end else if (spi_rx_data[3:0] == CMD_TX_RESET) begin
                        state_next = ST_RESET;
                    end
                end
            end
            ST_RESET: begin
                reset_go   = 1'b1;
                state_next = ST_IDLE;
            end
            ST_STATUS: begin
                status_go  = 1'b1;
                state_next = ST_HIGH;
            end
            ST_HIGH: begin
                if (spi_rx_strobe) begin
                    high_go    = 1'b1;
                    state_next = ST_LOW;
                end
            end
            ST_LOW: begin
                if (spi_rx_strobe) begin
                    low_go     = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!tx_full) begin
                    load_go    = 1'b1;
                    state_next = ST_STATUS;
                end else begin
`ifdef TX_STALL_EN
                    state_next = ST_LOAD;
`else
                    drop_go    = 1'b1;
                    state_next = ST_STATUS;
`endif
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Deselect aborts everything except a load decided in ST_LOAD this cycle.
        if (spi_cs) begin
            state_next = ST_IDLE;
            start_go   = 1'b0;
            status_go  = 1'b0;
            high_go    = 1'b0;
            low_go     = 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_control.sv
// Directed self-checking bench for tx_control (default build or with TX_STALL_EN).
module tb_tx_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_cs;
    logic [7:0]  spi_rx_data;
    logic        spi_rx_strobe;
    logic [7:0]  spi_tx_data;
    logic        spi_tx_strobe;
    logic        tx_reset;
    logic        tx_active;
    logic        tx_full;
    logic [9:0]  tx_data;
    logic        tx_load_strobe;
    logic [15:0] word_count;

    tx_control dut (
        .clk(clk), .reset(reset), .spi_cs(spi_cs),
        .spi_rx_data(spi_rx_data), .spi_rx_strobe(spi_rx_strobe),
        .spi_tx_data(spi_tx_data), .spi_tx_strobe(spi_tx_strobe),
        .tx_reset(tx_reset), .tx_active(tx_active), .tx_full(tx_full),
        .tx_data(tx_data), .tx_load_strobe(tx_load_strobe),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int load_cnt = 0, status_cnt = 0, rst_cnt = 0;
    int load_cyc = 0, status_cyc = 0, sent_cyc = 0;
    logic [9:0] load_data = '0;
    logic [7:0] status_byte = '0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (tx_load_strobe) begin load_cnt++; load_cyc = cyc; load_data = tx_data; end
        if (spi_tx_strobe) begin status_cnt++; status_cyc = cyc; status_byte = spi_tx_data; end
        if (tx_reset) rst_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        spi_rx_data   = b;
        spi_rx_strobe = 1'b1;
        sent_cyc      = cyc;
        @(negedge clk);
        spi_rx_strobe = 1'b0;
        idle(3);
    endtask

    task automatic deselect();
        @(negedge clk); spi_cs = 1'b1;
        @(negedge clk); spi_cs = 1'b0;
    endtask

    int l0, s0, r0, low_at;

    initial begin
        reset = 1'b1; spi_cs = 1'b0; spi_rx_data = 8'h00; spi_rx_strobe = 1'b0;
        tx_active = 1'b0; tx_full = 1'b0;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_spi_tx_data", spi_tx_data, 0);
        check("rst_strobes", {spi_tx_strobe, tx_reset, tx_load_strobe}, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_word_count", word_count, 0);

        // basic word load
        send_byte(8'h04);
        check("t1_status_cnt", status_cnt, 1);
        check("t1_status0", status_byte, 8'h00);
        send_byte(8'h02);
        send_byte(8'h5A);
        low_at = sent_cyc;
        idle(4);
        check("t1_load_cnt", load_cnt, 1);
        check("t1_tx_data", load_data, 10'h25A);
        check("t1_load_latency", load_cyc - low_at, 2);
        check("t1_word_count", word_count, 1);
        check("t1_status_cnt2", status_cnt, 2);
        check("t1_status_latency", status_cyc - low_at, 3);
        check("t1_status1", status_byte, 8'h00);
        check("t1_tx_data_hold", tx_data, 10'h25A);
        deselect();

        // tx reset command
        s0 = status_cnt; r0 = rst_cnt;
        send_byte(8'h06);
        idle(2);
        check("t2_reset_width", rst_cnt - r0, 1);
        check("t2_no_status", status_cnt - s0, 0);

        // tx_full during load
        l0 = load_cnt;
        tx_full = 1'b1;
        send_byte(8'h04);
        check("t3_status_full", status_byte, 8'h80);
        check("t3_word_count_clr", word_count, 0);
        send_byte(8'h01);
        send_byte(8'hFF);
`ifdef TX_STALL_EN
        idle(20);
        check("t4_stalled_no_load", load_cnt - l0, 0);
        @(negedge clk);
        tx_full = 1'b0;
        low_at  = cyc;
        idle(4);
        check("t4_load_cnt", load_cnt - l0, 1);
        check("t4_load_timing", load_cyc - low_at, 1);
        check("t4_tx_data", load_data, 10'h1FF);
        check("t4_status", status_byte, 8'h00);
        check("t4_word_count", word_count, 1);
`else
        idle(2);
        check("t3_no_load", load_cnt - l0, 0);
        check("t3_status_ovf", status_byte, 8'hC0);
        check("t3_word_count", word_count, 0);
        tx_full = 1'b0;
`endif
        deselect();

        // abort with spi_cs, then a fresh transaction
        l0 = load_cnt;
        send_byte(8'h04);
        send_byte(8'h03);
        deselect();
        idle(3);
        check("t5_abort_no_load", load_cnt - l0, 0);
        check("t5_abort_count", word_count, 0);
        send_byte(8'h04);
        send_byte(8'h00);
        send_byte(8'h11);
        idle(2);
        check("t5_load_cnt", load_cnt - l0, 1);
        check("t5_tx_data", tx_data, 10'h011);
        check("t5_word_count", word_count, 1);
        deselect();

        // tx_active reporting and invalid command
        tx_active = 1'b1;
        send_byte(8'h04);
        check("t6_status_active", status_byte, 8'h20);
        deselect();
        tx_active = 1'b0;
        s0 = status_cnt; r0 = rst_cnt; l0 = load_cnt;
        send_byte(8'h09);
        send_byte(8'h02);
        send_byte(8'h5A);
        idle(3);
        check("t6_invalid_status", status_cnt - s0, 0);
        check("t6_invalid_reset", rst_cnt - r0, 0);
        check("t6_invalid_load", load_cnt - l0, 0);

        // reset mid-transaction
        send_byte(8'h04);
        send_byte(8'h01);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        l0 = load_cnt;
        check("t7_reset_count", word_count, 0);
        check("t7_reset_tx_data", tx_data, 0);
        send_byte(8'h22);
        idle(3);
        check("t7_reset_idle_no_load", load_cnt - l0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_control.md
Name: tx_control

Overview:
- SPI-side command handler for the coax transmit path.
- Decodes the TX command byte from the SPI slave, assembles 10-bit coax words from byte pairs, and loads them into the transmitter FIFO with a one-cycle strobe.
- Reports transmitter status back to the host on every word.
- Also decodes a TX-reset command that pulses the transmitter reset.

Parameters:
- CMD_TX, 4'h4, low-nibble command code that starts a word-load transaction.
- CMD_TX_RESET, 4'h6, low-nibble command code that pulses tx_reset.
- COUNT_WIDTH, 16, width of the per-transaction loaded-word counter (saturating).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- spi_cs  input  1  high = host deselected; forces IDLE.
- spi_rx_data  input  8  byte received from host.
- spi_rx_strobe  input  1  one-cycle pulse, spi_rx_data valid.
- spi_tx_data  output  8  byte to shift out to host.
- spi_tx_strobe  output  1  one-cycle pulse, spi_tx_data valid.
- tx_reset  output  1  one-cycle transmitter reset pulse.
- tx_active  input  1  transmitter currently sending.
- tx_full  input  1  TX FIFO full.
- tx_data  output  10  word to load into TX FIFO.
- tx_load_strobe  output  1  one-cycle FIFO write pulse.
- word_count  output  COUNT_WIDTH  words loaded in current or last transaction.

Behaviour:
- All outputs are registered.
- On reset: state = IDLE; spi_tx_data = 0, spi_tx_strobe = 0, tx_reset = 0, tx_data = 0, tx_load_strobe = 0, word_count = 0; overflow flag and word buffer = 0.
- IDLE:
  - On spi_rx_strobe, the command byte is latched.
  - Low nibble == CMD_TX → clear overflow and word_count, go to TX_STATUS.
  - Low nibble == CMD_TX_RESET → go to TX_RESET.
  - Any other value → stay in IDLE.
- TX_RESET: tx_reset = 1 for exactly one cycle; next state IDLE.
- TX_STATUS:
  - spi_tx_data = {tx_full, overflow, tx_active, 5'b0}, spi_tx_strobe = 1 for one cycle.
  - Next state TX_HIGH.
- TX_HIGH: wait for spi_rx_strobe; word_buffer[9:8] = spi_rx_data[1:0] (bits 7:2 ignored); next state TX_LOW.
- TX_LOW: wait for spi_rx_strobe; word_buffer[7:0] = spi_rx_data; next state TX_LOAD.
- TX_LOAD:
  - If tx_full = 0: tx_data = word_buffer, tx_load_strobe = 1 for one cycle, word_count += 1 (saturates at all-ones).
  - If tx_full = 1: word is dropped and overflow is set (sticky until the next CMD_TX).
  - Next state TX_STATUS.
- Latency: the low-byte spi_rx_strobe in cycle N gives tx_load_strobe in cycle N+2.
- tx_data holds its value between loads.
- spi_tx_strobe for the next status byte occurs in cycle N+3.
- spi_cs high in any state: next state IDLE and a partial word is discarded.
  - No load strobe is issued unless the state was already TX_LOAD in that cycle; a strobe already registered completes.
  - word_count and overflow retain their values.
- spi_rx_strobe in TX_STATUS or TX_LOAD is ignored. The host must not send a byte within two clocks of the previous one.
- tx_full is sampled only in TX_LOAD.
- reset asserted mid-transaction: all state is cleared next cycle, no strobes.

Optional Feature:
- Macro: TX_STALL_EN.
- Defined:
  - TX_LOAD with tx_full = 1 stays in TX_LOAD until tx_full = 0, then loads as normal.
  - overflow is never set.
  - spi_cs high still exits to IDLE and drops the word.
- Undefined: drop-and-flag behaviour as specified in Behaviour.

Test Plan:
- Command 0x04, then bytes 0x02, 0x5A, tx_full = 0 → status byte 0x00 strobed first; tx_data = 10'h25A with one tx_load_strobe 2 clocks after 0x5A; word_count = 1; second status byte 0x00.
- Command 0x06 → tx_reset high exactly one cycle, back to IDLE, no spi_tx_strobe.
- Command 0x04, tx_full = 1 held, bytes 0x01, 0xFF (stall macro undefined) → no tx_load_strobe; next status byte 0xC0 (tx_full and overflow set); word_count = 0.
- Same stimulus with TX_STALL_EN, releasing tx_full after 20 clocks → tx_load_strobe with tx_data = 10'h1FF in the cycle after tx_full falls; status byte has overflow = 0.
- Command 0x04, byte 0x03, then spi_cs high → IDLE next cycle, no load. New 0x04 transaction with 0x00, 0x11 → tx_data = 10'h011; word_count = 1.
- Command 0x04 with tx_active = 1 → status byte 0x20. Invalid command 0x09 → no response, stays in IDLE.
